// File: rtl/canny_edge_stream.sv
// Valid/ready, frame-aware wrapper around a fixed-latency binary edge pipeline.
// Admission is credit-gated so the core's non-stallable output never overruns the output FIFO.

module canny_edge_core #(
    parameter int                DATA_W      = 8,
    parameter int                CORE_LAT    = 4,
    parameter logic [DATA_W-1:0] EDGE_THRESH = DATA_W'(32'd40)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_in_valid,
    output logic [DATA_W-1:0] pixel_out,
    output logic              pixel_out_valid
);
    logic [DATA_W-1:0]   prev_q;
    logic [DATA_W-1:0]   diff_s;
    logic [DATA_W-1:0]   edge_s;
    logic [CORE_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   pix_q [CORE_LAT];

    // Gradient against the previous input pixel, thresholded to a binary edge value
    always_comb begin
        diff_s = {DATA_W{1'b0}};
        edge_s = {DATA_W{1'b0}};
        if (pixel_in >= prev_q) begin
            diff_s = pixel_in - prev_q;
        end else begin
            diff_s = prev_q - pixel_in;
        end
        if (diff_s > EDGE_THRESH) begin
            edge_s = {DATA_W{1'b1}};
        end else begin
            edge_s = {DATA_W{1'b0}};
        end
    end

    // Previous-pixel history, advanced on every valid input
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prev_q <= {DATA_W{1'b0}};
        end else if (pixel_in_valid) begin
            prev_q <= pixel_in;
        end
    end

    // Fixed-latency delay line carrying the edge result and its valid
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld_q <= {CORE_LAT{1'b0}};
            for (int i = 0; i < CORE_LAT; i++) begin
                pix_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            vld_q[0] <= pixel_in_valid;
            pix_q[0] <= edge_s;
            for (int i = 1; i < CORE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                pix_q[i] <= pix_q[i-1];
            end
        end
    end

    assign pixel_out_valid = vld_q[CORE_LAT-1];
    assign pixel_out       = pix_q[CORE_LAT-1];
endmodule

module canny_edge_stream #(
    parameter int                DATA_W      = 8,
    parameter int                CORE_LAT    = 4,
    parameter int                FIFO_DEPTH  = 16,
    parameter int                OUT_WIDTH   = 636,
    parameter int                OUT_HEIGHT  = 476,
    parameter logic [DATA_W-1:0] EDGE_THRESH = DATA_W'(32'd40)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] s_pixel,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_pixel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic [15:0]       frame_count,
    output logic              overflow_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IFL_W = $clog2(CORE_LAT + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int COL_W = $clog2(OUT_WIDTH + 1);
    localparam int ROW_W = $clog2(OUT_HEIGHT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_HEIGHT - 1);

    logic                accept_s;
    logic                core_vld_s;
    logic [DATA_W-1:0]   core_pix_s;
    logic                pop_s;
    logic                full_s;
    logic                wr_en_s;
    logic [IFL_W-1:0]    inflight_s;
    logic [SUM_W-1:0]    credit_s;
    logic [CORE_LAT-1:0] inflight_q, inflight_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [15:0]         frame_q, frame_d;
    logic                ovf_q, ovf_d;

    canny_edge_core #(
        .DATA_W      (DATA_W),
        .CORE_LAT    (CORE_LAT),
        .EDGE_THRESH (EDGE_THRESH)
    ) u_core (
        .clk             (clk),
        .rstN            (rstN),
        .pixel_in        (s_pixel),
        .pixel_in_valid  (accept_s),
        .pixel_out       (core_pix_s),
        .pixel_out_valid (core_vld_s)
    );

    // Accepted pixels whose output slot has not yet reached the FIFO
    always_comb begin
        inflight_s = {IFL_W{1'b0}};
        for (int i = 0; i < CORE_LAT; i++) begin
            inflight_s = inflight_s + IFL_W'(inflight_q[i]);
        end
    end

    assign credit_s = SUM_W'(count_q) + SUM_W'(inflight_s);
    assign s_ready  = (credit_s < SUM_W'(FIFO_DEPTH));
    assign accept_s = s_valid && s_ready;
    assign m_valid  = (count_q != {CNT_W{1'b0}});
    assign pop_s    = m_valid && m_ready;
    assign full_s   = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still kept
    assign wr_en_s  = core_vld_s && (!full_s || pop_s);

    assign m_pixel      = m_valid ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
    assign m_sof        = m_valid && (col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}});
    assign m_eol        = m_valid && (col_q == COL_LAST);
    assign frame_count  = frame_q;
    assign overflow_err = ovf_q;

    // Next-state for credit tracking, FIFO bookkeeping, frame position and overflow
    always_comb begin
        inflight_d    = {CORE_LAT{1'b0}};
        inflight_d[0] = accept_s;
        for (int i = 1; i < CORE_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        col_d    = col_q;
        row_d    = row_q;
        frame_d  = frame_q;
        ovf_d    = ovf_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_en_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en_s && pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        if (core_vld_s && !wr_en_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (pop_s && (col_q == COL_LAST)) begin
            col_d = {COL_W{1'b0}};
            if (row_q == ROW_LAST) begin
                row_d   = {ROW_W{1'b0}};
                frame_d = frame_q + 16'd1;
            end else begin
                row_d   = row_q + ROW_W'(1);
                frame_d = frame_q;
            end
        end else if (pop_s) begin
            col_d = col_q + COL_W'(1);
        end else begin
            col_d = col_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inflight_q <= {CORE_LAT{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            col_q      <= {COL_W{1'b0}};
            row_q      <= {ROW_W{1'b0}};
            frame_q    <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            col_q      <= col_d;
            row_q      <= row_d;
            frame_q    <= frame_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage; stale entries are never visible because m_pixel is gated by m_valid
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= core_pix_s;
        end
    end
endmodule

// File: tb/tb_canny_edge_stream.sv
// Directed, table-driven bench for canny_edge_stream with a scoreboard model of the edge core.

module tb_canny_edge_stream;
    localparam int DW = 8, LAT = 4, DEPTH = 16, OW = 6, OH = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic [DW-1:0] s_pixel;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_pixel;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eol;
    logic [15:0]   frame_count;
    logic          overflow_err;

    canny_edge_stream #(
        .DATA_W(DW), .CORE_LAT(LAT), .FIFO_DEPTH(DEPTH), .OUT_WIDTH(OW), .OUT_HEIGHT(OH)
    ) dut (
        .clk(clk), .rstN(rstN), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
        .frame_count(frame_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] edge_v;
        logic       sof;
        logic       eol;
    } vec_t;

    vec_t       tbl [12];
    int         n_chk = 0, n_fail = 0;
    int         cyc = 0;
    logic [7:0] mq [$];
    logic [7:0] mprev;
    int         mcol, mrow, n_acc, n_pop, first_acc_cyc, first_vld_cyc, sready_low;
    bit         hold_v;
    logic [7:0] hold_pix;
    logic       hold_sof, hold_eol;
    logic [7:0] cap_pix [$];
    logic       cap_sof [$];
    logic       cap_eol [$];
    logic [7:0] head;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] edge_of(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] d;
        d = (p >= q) ? p - q : q - p;
        return (d > 8'd40) ? 8'hFF : 8'h00;
    endfunction

    // One clock: update the model from pre-edge handshakes, then advance past the edge
    task automatic step();
        logic acc, pp;
        acc = s_valid && s_ready;
        pp  = m_valid && m_ready;
        if (s_ready !== 1'b1) sready_low++;
        if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (hold_v) begin
            chk("stall_pix", m_pixel, hold_pix);
            chk("stall_side", {m_valid, m_sof, m_eol}, {1'b1, hold_sof, hold_eol});
        end
        if (!m_valid) chk("idle_side", {m_sof, m_eol}, 2'b00);
        hold_v   = m_valid && !m_ready;
        hold_pix = m_pixel;
        hold_sof = m_sof;
        hold_eol = m_eol;
        if (acc) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            mq.push_back(edge_of(s_pixel, mprev));
            mprev = s_pixel;
            n_acc++;
        end
        if (pp) begin
            cap_pix.push_back(m_pixel);
            cap_sof.push_back(m_sof);
            cap_eol.push_back(m_eol);
            chk("sb_nonempty", (mq.size() > 0), 1);
            if (mq.size() > 0) chk("pop_pixel", m_pixel, mq.pop_front());
            chk("pop_sof", m_sof, (mcol == 0 && mrow == 0));
            chk("pop_eol", m_eol, (mcol == OW - 1));
            if (mcol == OW - 1) begin
                mcol = 0;
                mrow = (mrow == OH - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
            n_pop++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0; s_pixel = 8'h00;
        mq.delete(); cap_pix.delete(); cap_sof.delete(); cap_eol.delete();
        mprev = 8'h00; mcol = 0; mrow = 0; n_acc = 0; n_pop = 0;
        first_acc_cyc = -1; first_vld_cyc = -1; sready_low = 0; hold_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        // Hand-computed 6x2 frame: edge when |p - prev| > 40, prev starts at 0
        tbl[0]  = '{8'd10,  8'h00, 1'b1, 1'b0};
        tbl[1]  = '{8'd80,  8'hFF, 1'b0, 1'b0};
        tbl[2]  = '{8'd85,  8'h00, 1'b0, 1'b0};
        tbl[3]  = '{8'd20,  8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{8'd20,  8'h00, 1'b0, 1'b0};
        tbl[5]  = '{8'd200, 8'hFF, 1'b0, 1'b1};
        tbl[6]  = '{8'd190, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{8'd100, 8'hFF, 1'b0, 1'b0};
        tbl[8]  = '{8'd60,  8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'd61,  8'h00, 1'b0, 1'b0};
        tbl[10] = '{8'd0,   8'hFF, 1'b0, 1'b0};
        tbl[11] = '{8'd255, 8'hFF, 1'b0, 1'b1};

        rstN = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_pixel = 8'h00;
        #3;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_pixel", m_pixel, 0);
        chk("rst_side", {m_sof, m_eol}, 0);
        chk("rst_frame", frame_count, 0);
        chk("rst_ovf", overflow_err, 0);

        // Full-rate stream of one synthetic frame
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_pixel = tbl[i].pix;
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 20 && n_pop < 12; i++) step();
        chk("full_pops", n_pop, 12);
        chk("full_latency", first_vld_cyc - first_acc_cyc, LAT + 1);
        chk("full_sready_low", sready_low, 0);
        chk("full_frame", frame_count, 1);
        for (int i = 0; i < 12; i++) begin
            if (i < cap_pix.size()) begin
                chk("tbl_pix", cap_pix[i], tbl[i].edge_v);
                chk("tbl_sof", cap_sof[i], tbl[i].sof);
                chk("tbl_eol", cap_eol[i], tbl[i].eol);
            end
        end

        // Backpressure from reset
        do_reset();
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_pixel = 8'($urandom);
            step();
        end
        chk("bp_accepts", n_acc, DEPTH);
        chk("bp_sready", s_ready, 0);
        chk("bp_ovf", overflow_err, 0);
        chk("bp_count", dut.count_q, DEPTH);
        chk("bp_mvalid", m_valid, 1);

        // Recovery: single pop pulse reopens exactly one credit
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("rec_sready_up", s_ready, 1);
        s_valid = 1'b1;
        s_pixel = 8'h77;
        step();
        chk("rec_sready_down", s_ready, 0);
        chk("rec_accepts", n_acc, DEPTH + 1);
        repeat (10) step();
        chk("rec_hold", n_acc, DEPTH + 1);
        chk("rec_sready_stays", s_ready, 0);

        // Random handshakes over 10 frames
        do_reset();
        for (int i = 0; i < 6000 && n_pop < 120; i++) begin
            int f;
            f = n_pop / 12;
            s_valid = (n_acc < 120) && ($urandom_range(0, 99) < 30 + 6 * f);
            m_ready = ($urandom_range(0, 99) < 90 - 6 * f);
            s_pixel = 8'($urandom);
            step();
        end
        chk("rnd_pops", n_pop, 120);
        chk("rnd_frames", frame_count, 10);
        chk("rnd_ovf", overflow_err, 0);

        // Forced core push into a full FIFO with no pop
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_pixel = 8'($urandom);
            step();
        end
        s_valid = 1'b0;
        repeat (5) step();
        chk("ovf_pre_count", dut.count_q, DEPTH);
        head = mq[0];
        force dut.core_vld_s = 1'b1;
        @(posedge clk);
        #1;
        release dut.core_vld_s;
        chk("ovf_set", overflow_err, 1);
        chk("ovf_head", m_pixel, head);
        chk("ovf_count", dut.count_q, DEPTH);
        repeat (5) step();
        chk("ovf_sticky", overflow_err, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && n_pop < DEPTH; i++) step();
        chk("ovf_drain", n_pop, DEPTH);
        chk("ovf_after_drain", overflow_err, 1);
        chk("ovf_frame", frame_count, 1);

        // Reset mid-stream with 5 entries queued
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_pixel = 8'($urandom);
            step();
        end
        s_valid = 1'b0;
        repeat (6) step();
        chk("mid_queued", dut.count_q, 5);
        rstN = 1'b0;
        #1;
        chk("mid_mvalid", m_valid, 0);
        chk("mid_sready", s_ready, 1);
        chk("mid_frame", frame_count, 0);
        chk("mid_ovf", overflow_err, 0);
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_pixel = 8'h90;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 20 && n_pop < 1; i++) step();
        chk("mid_first_pop", n_pop, 1);
        chk("mid_first_sof", (cap_sof.size() > 0) ? cap_sof[0] : 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
